// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard unit: EX-stage operand forwarding, load-use / RAW / multi-cycle
// stall detection, a small FSM tracking one in-flight multi-cycle op, and a stall counter.
module hazard_fwd_unit #(
  parameter int REGS_W = 5,
  parameter int FWD_EN = 1,
  parameter int MC_LAT = 4,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_mc,
  input  logic [REGS_W-1:0] id_rs1,
  input  logic [REGS_W-1:0] id_rs2,
  input  logic [REGS_W-1:0] ex_rs1,
  input  logic [REGS_W-1:0] ex_rs2,
  input  logic [REGS_W-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_mc_start,
  input  logic [REGS_W-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REGS_W-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_ex,
  output logic              mc_busy,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam int CNT_W = $clog2(MC_LAT + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [REGS_W-1:0]  pend_rd_q, pend_rd_d;
  logic [CNT_W-1:0]   mc_cnt_q, mc_cnt_d;
  logic [PERF_W-1:0]  stall_cnt_q;

  logic mem_fwd_ok, wb_fwd_ok;
  logic ex_hit, mem_hit, pend_hit;
  logic load_use, raw_hz, mc_hz, hazard;

  assign mem_fwd_ok = mem_regwrite && (mem_rd != '0);
  assign wb_fwd_ok  = wb_regwrite && (wb_rd != '0);

  // EX/MEM has the younger value, so it wins over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN != 0) begin
      if (mem_fwd_ok && (mem_rd == ex_rs1))     fwd_a = 2'b10;
      else if (wb_fwd_ok && (wb_rd == ex_rs1))  fwd_a = 2'b01;
      if (mem_fwd_ok && (mem_rd == ex_rs2))     fwd_b = 2'b10;
      else if (wb_fwd_ok && (wb_rd == ex_rs2))  fwd_b = 2'b01;
    end
  end

  assign ex_hit   = (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign mem_hit  = (mem_rd != '0) && ((mem_rd == id_rs1) || (mem_rd == id_rs2));
  assign pend_hit = (pend_rd_q != '0) && ((pend_rd_q == id_rs1) || (pend_rd_q == id_rs2));

  assign load_use = ex_memread && ex_hit;
  // Without forwarding, EX and MEM producers must drain; WB is covered by write-first RF.
  assign raw_hz   = (FWD_EN == 0) && ((ex_regwrite && ex_hit) || (mem_regwrite && mem_hit));
  assign mc_hz    = (mc_busy && pend_hit) || (ex_mc_start && ex_hit) ||
                    (id_mc && (mc_busy || ex_mc_start));
  assign hazard   = id_valid && (load_use || raw_hz || mc_hz);

  assign stall_if = hazard;
  assign stall_id = hazard;
  assign flush_ex = hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_rd_q <= '0;
      mc_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      mc_cnt_q  <= mc_cnt_d;
    end
  end

  // A start while already busy is a protocol violation and is dropped.
  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    mc_cnt_d  = mc_cnt_q;
    mc_busy   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_mc_start) begin
          state_d   = MC_BUSY;
          pend_rd_d = ex_rd;
          mc_cnt_d  = CNT_W'(MC_LAT - 1);
        end
      end
      MC_BUSY: begin
        mc_busy = 1'b1;
        if (mc_cnt_q == CNT_W'(1)) begin
          state_d   = IDLE;
          pend_rd_d = '0;
          mc_cnt_d  = '0;
        end else begin
          mc_cnt_d  = mc_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        pend_rd_d = '0;
        mc_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_id && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: two instances (forwarding / 4-cycle MC / 32-bit counter and
// stall-only / 3-cycle MC / 4-bit counter) share one stimulus and are checked against a model.
module tb_hazard_fwd_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid, id_mc;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_regwrite, ex_memread, ex_mc_start, mem_regwrite, wb_regwrite;

  logic [1:0]  a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b;
  logic        a_stall_if, a_stall_id, a_flush_ex, a_mc_busy;
  logic        b_stall_if, b_stall_id, b_flush_ex, b_mc_busy;
  logic [31:0] a_stall_cnt;
  logic [3:0]  b_stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_fwd_unit #(.REGS_W(5), .FWD_EN(1), .MC_LAT(4), .PERF_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_mc(id_mc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_mc_start(ex_mc_start),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .stall_if(a_stall_if), .stall_id(a_stall_id),
    .flush_ex(a_flush_ex), .mc_busy(a_mc_busy), .stall_cnt(a_stall_cnt));

  hazard_fwd_unit #(.REGS_W(5), .FWD_EN(0), .MC_LAT(3), .PERF_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_mc(id_mc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_mc_start(ex_mc_start),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .stall_if(b_stall_if), .stall_id(b_stall_id),
    .flush_ex(b_flush_ex), .mc_busy(b_mc_busy), .stall_cnt(b_stall_cnt));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a multi-cycle op accepted in cycle c keeps the unit busy for
  // cycles c+1 .. c+LAT-1; stall count is min(stall cycles, all-ones).
  int         cyc;
  int         busy_until[2];
  logic [4:0] pend[2];
  longint     scnt[2];
  int         LAT[2] = '{4, 3};
  longint     SAT[2] = '{64'hFFFF_FFFF, 15};

  function automatic bit m_busy(int k);
    return cyc <= busy_until[k];
  endfunction

  function automatic logic [1:0] m_fwd(int k, logic [4:0] rs);
    if (k == 1) return 2'b00;
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit reads(logic [4:0] r);
    return (r != 0) && (r == id_rs1 || r == id_rs2);
  endfunction

  function automatic bit m_stall(int k);
    bit s;
    if (!id_valid) return 1'b0;
    s = ex_memread && reads(ex_rd);
    if (k == 1) s = s || (ex_regwrite && reads(ex_rd)) || (mem_regwrite && reads(mem_rd));
    s = s || (m_busy(k) && reads(pend[k]));
    s = s || (ex_mc_start && reads(ex_rd));
    s = s || (id_mc && (m_busy(k) || ex_mc_start));
    return s;
  endfunction

  function automatic logic [7:0] m_vec(int k);
    bit s;
    s = m_stall(k);
    return {m_fwd(k, ex_rs1), m_fwd(k, ex_rs2), s, s, s, m_busy(k)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busy_until[k] = -1;
      pend[k]       = 5'd0;
      scnt[k]       = 0;
    end
  endtask

  task automatic model_edge();
    bit s;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        s = m_stall(k);
        if (s) scnt[k] = (scnt[k] + 1 > SAT[k]) ? SAT[k] : scnt[k] + 1;
        if (!m_busy(k) && ex_mc_start) begin
          busy_until[k] = cyc + LAT[k] - 1;
          pend[k]       = ex_rd;
        end
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_mc = 0; id_rs1 = 0; id_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    ex_regwrite = 0; ex_memread = 0; ex_mc_start = 0;
    mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
  endtask

  task automatic random_inputs();
    id_valid     = 1'($urandom_range(0, 1));
    id_mc        = ($urandom_range(0, 3) == 0);
    id_rs1       = 5'($urandom_range(0, 3));
    id_rs2       = 5'($urandom_range(0, 3));
    ex_rs1       = 5'($urandom_range(0, 3));
    ex_rs2       = 5'($urandom_range(0, 3));
    ex_rd        = 5'($urandom_range(0, 3));
    ex_regwrite  = 1'($urandom_range(0, 1));
    ex_memread   = ($urandom_range(0, 3) == 0);
    ex_mc_start  = ($urandom_range(0, 7) == 0);
    mem_rd       = 5'($urandom_range(0, 3));
    mem_regwrite = 1'($urandom_range(0, 1));
    wb_rd        = 5'($urandom_range(0, 3));
    wb_regwrite  = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    model_reset();
    #2;
    for (int i = 0; i < 4; i++) begin
      random_inputs();
      #1;
      checks++;
      if ({a_mc_busy, a_stall_cnt, b_mc_busy, b_stall_cnt} !== 38'd0) begin
        errors++;
        $display("FAIL reset_regs: busy/cnt a=%b/%0d b=%b/%0d, expected all zero",
                 a_mc_busy, a_stall_cnt, b_mc_busy, b_stall_cnt);
      end
      checks++;
      if ({a_fwd_a, a_fwd_b, a_stall_if, a_stall_id, a_flush_ex, a_mc_busy} !== m_vec(0)) begin
        errors++;
        $display("FAIL reset_comb_a: got %b expected %b",
                 {a_fwd_a, a_fwd_b, a_stall_if, a_stall_id, a_flush_ex, a_mc_busy}, m_vec(0));
      end
      checks++;
      if ({b_fwd_a, b_fwd_b, b_stall_if, b_stall_id, b_flush_ex, b_mc_busy} !== m_vec(1)) begin
        errors++;
        $display("FAIL reset_comb_b: got %b expected %b",
                 {b_fwd_a, b_fwd_b, b_stall_if, b_stall_id, b_flush_ex, b_mc_busy}, m_vec(1));
      end
      tick();
    end
    clear_inputs();
    rst_n = 1;
    tick();
  endtask

  task automatic test_priority();
    clear_inputs();
    ex_rs1 = 3; ex_rs2 = 3; mem_rd = 3; wb_rd = 3; mem_regwrite = 1; wb_regwrite = 1;
    #1;
    checks++;
    if ({a_fwd_a, a_fwd_b, b_fwd_a} !== 6'b10_10_00) begin
      errors++;
      $display("FAIL prio_mem: a_fwd_a=%b a_fwd_b=%b b_fwd_a=%b, expected 10 10 00", a_fwd_a, a_fwd_b, b_fwd_a);
    end
    mem_regwrite = 0;
    #1;
    checks++;
    if ({a_fwd_a, a_fwd_b} !== 4'b01_01) begin
      errors++;
      $display("FAIL prio_wb: a_fwd_a=%b a_fwd_b=%b, expected 01 01", a_fwd_a, a_fwd_b);
    end
    ex_rs1 = 0;
    #1;
    checks++;
    if ({a_fwd_a, a_fwd_b} !== 4'b00_01) begin
      errors++;
      $display("FAIL prio_x0: a_fwd_a=%b a_fwd_b=%b, expected 00 01", a_fwd_a, a_fwd_b);
    end
    tick();
  endtask

  task automatic test_load_use();
    longint s0;
    clear_inputs();
    ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_valid = 1;
    s0 = scnt[0];
    #1;
    checks++;
    if ({a_stall_if, a_stall_id, a_flush_ex} !== 3'b111) begin
      errors++;
      $display("FAIL load_use_stall: got %b expected 111", {a_stall_if, a_stall_id, a_flush_ex});
    end
    tick();
    checks++;
    if (a_stall_cnt !== 32'(s0 + 1)) begin
      errors++;
      $display("FAIL load_use_cnt: got %0d expected %0d", a_stall_cnt, s0 + 1);
    end
    id_valid = 0;
    #1;
    checks++;
    if ({a_stall_if, a_stall_id, a_flush_ex} !== 3'b000) begin
      errors++;
      $display("FAIL load_use_novalid: got %b expected 000", {a_stall_if, a_stall_id, a_flush_ex});
    end
    tick();
    checks++;
    if (a_stall_cnt !== 32'(s0 + 1)) begin
      errors++;
      $display("FAIL load_use_cnt_hold: got %0d expected %0d", a_stall_cnt, s0 + 1);
    end
  endtask

  task automatic test_multicycle();
    longint s0;
    clear_inputs();
    ex_mc_start = 1; ex_rd = 7; id_rs1 = 7; id_valid = 1;
    s0 = scnt[0];
    for (int c = 0; c <= 4; c++) begin
      #1;
      checks++;
      if ({a_stall_id, a_mc_busy} !== {1'(c < 4), 1'(c >= 1 && c <= 3)}) begin
        errors++;
        $display("FAIL mc_cycle%0d: stall/busy=%b%b expected %b%b", c, a_stall_id, a_mc_busy,
                 1'(c < 4), 1'(c >= 1 && c <= 3));
      end
      tick();
      ex_mc_start = 0;
      ex_rd = 0;
    end
    checks++;
    if (a_stall_cnt !== 32'(s0 + 4)) begin
      errors++;
      $display("FAIL mc_cnt: got %0d expected %0d", a_stall_cnt, s0 + 4);
    end
  endtask

  task automatic test_structural();
    clear_inputs();
    ex_mc_start = 1; ex_rd = 10;
    tick();
    ex_mc_start = 0; ex_rd = 0; id_valid = 1; id_mc = 1;
    #1;
    checks++;
    if ({a_stall_id, a_mc_busy} !== 2'b11) begin
      errors++;
      $display("FAIL struct_c1: stall/busy=%b%b expected 11", a_stall_id, a_mc_busy);
    end
    tick();
    ex_mc_start = 1; ex_rd = 12;
    #1;
    checks++;
    if ({a_stall_id, a_mc_busy} !== 2'b11) begin
      errors++;
      $display("FAIL struct_c2: stall/busy=%b%b expected 11", a_stall_id, a_mc_busy);
    end
    tick();
    ex_mc_start = 0; ex_rd = 0; id_mc = 0; id_rs1 = 12;
    #1;
    checks++;
    if ({a_stall_id, a_mc_busy} !== 2'b01) begin
      errors++;
      $display("FAIL struct_pend_kept: stall/busy=%b%b expected 01", a_stall_id, a_mc_busy);
    end
    id_rs1 = 10;
    #1;
    checks++;
    if (a_stall_id !== 1'b1) begin
      errors++;
      $display("FAIL struct_pend_hit: stall=%b expected 1", a_stall_id);
    end
    tick();
    id_mc = 1;
    #1;
    checks++;
    if ({a_stall_id, a_mc_busy} !== 2'b00) begin
      errors++;
      $display("FAIL struct_done: stall/busy=%b%b expected 00", a_stall_id, a_mc_busy);
    end
    tick();
  endtask

  task automatic test_fwd_disabled();
    clear_inputs();
    mem_regwrite = 1; mem_rd = 9; id_rs1 = 9; id_valid = 1; ex_rs1 = 9;
    #1;
    checks++;
    if ({b_stall_id, b_fwd_a, a_stall_id, a_fwd_a} !== 6'b1_00_0_10) begin
      errors++;
      $display("FAIL nofwd_mem: b stall/fwd=%b/%b a stall/fwd=%b/%b expected 1/00 0/10",
               b_stall_id, b_fwd_a, a_stall_id, a_fwd_a);
    end
    mem_rd = 0; id_rs1 = 0;
    #1;
    checks++;
    if (b_stall_id !== 1'b0) begin
      errors++;
      $display("FAIL nofwd_rd0: b stall=%b expected 0", b_stall_id);
    end
    ex_regwrite = 1; ex_rd = 9; id_rs2 = 9;
    #1;
    checks++;
    if ({b_stall_id, a_stall_id} !== 2'b10) begin
      errors++;
      $display("FAIL nofwd_ex: b/a stall=%b%b expected 10", b_stall_id, a_stall_id);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    clear_inputs();
    ex_mc_start = 1; ex_rd = 6;
    tick();
    ex_mc_start = 0; ex_rd = 0;
    tick();
    id_valid = 1; id_rs1 = 6;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if ({a_mc_busy, a_stall_cnt, a_stall_id} !== 34'd0) begin
      errors++;
      $display("FAIL reset_midop: busy=%b cnt=%0d stall=%b expected 0 0 0", a_mc_busy, a_stall_cnt, a_stall_id);
    end
    tick();
    rst_n = 1;
    clear_inputs();
    tick();
  endtask

  task automatic test_saturation();
    clear_inputs();
    id_valid = 1; ex_memread = 1; ex_rd = 5; id_rs1 = 5;
    for (int i = 0; i < 18; i++) begin
      tick();
      checks++;
      if (b_stall_cnt !== ((i >= 14) ? 4'hF : 4'(i + 1))) begin
        errors++;
        $display("FAIL sat_b%0d: got %0d expected %0d", i, b_stall_cnt, (i >= 14) ? 15 : i + 1);
      end
    end
    checks++;
    if (a_stall_cnt !== 32'd18) begin
      errors++;
      $display("FAIL sat_a: got %0d expected 18", a_stall_cnt);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      random_inputs();
      #1;
      checks++;
      if ({a_fwd_a, a_fwd_b, a_stall_if, a_stall_id, a_flush_ex, a_mc_busy} !== m_vec(0)) begin
        errors++;
        $display("FAIL rand_a%0d: got %b expected %b", i,
                 {a_fwd_a, a_fwd_b, a_stall_if, a_stall_id, a_flush_ex, a_mc_busy}, m_vec(0));
      end
      checks++;
      if ({b_fwd_a, b_fwd_b, b_stall_if, b_stall_id, b_flush_ex, b_mc_busy} !== m_vec(1)) begin
        errors++;
        $display("FAIL rand_b%0d: got %b expected %b", i,
                 {b_fwd_a, b_fwd_b, b_stall_if, b_stall_id, b_flush_ex, b_mc_busy}, m_vec(1));
      end
      checks++;
      if ({a_stall_cnt, b_stall_cnt} !== {32'(scnt[0]), 4'(scnt[1])}) begin
        errors++;
        $display("FAIL rand_cnt%0d: a=%0d b=%0d expected %0d %0d", i, a_stall_cnt, b_stall_cnt,
                 scnt[0], scnt[1]);
      end
      tick();
    end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_priority();
    test_load_use();
    test_multicycle();
    test_structural();
    test_fwd_disabled();
    test_reset_midop();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
